// File: rtl/seg_display_scheduler_if.sv
// Requester-side bundle of the seven-segment display scheduler: request/digit
// inputs and the registered display, ack and status outputs.
interface seg_display_scheduler_if #(
  parameter int NREQ      = 4,
  parameter int NBITS_SEG = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req;
  logic [4*NREQ-1:0]    value;
  logic [NBITS_SEG-1:0] SEG;
  logic [NREQ-1:0]      ack;
  logic                 busy;
  logic [IDW-1:0]       cur_id;

  modport master (output req, value, input SEG, ack, busy, cur_id);
  modport slave  (input req, value, output SEG, ack, busy, cur_id);
endinterface

// File: rtl/seg_display_scheduler.sv
// Round-robin sharing of one seven-segment display among NREQ requesters;
// each grant shows the decoded digit for HOLD_CYCLES clocks, then acks.
module seg_display_scheduler #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int NBITS_SEG   = 8
) (
  input  logic                    clk_2,
  input  logic                    reset,
  seg_display_scheduler_if.slave  bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [IDW-1:0]       cur_id, cur_id_d;
  logic [IDW-1:0]       last, last_d;
  logic [NBITS_SEG-1:0] seg, seg_d;
  logic                 grant_found;
  logic [IDW-1:0]       grant;
  logic [3:0]           grant_dig;

  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 8'h3F;
      4'd1:    decode = 8'h06;
      4'd2:    decode = 8'h5B;
      4'd3:    decode = 8'h4F;
      4'd4:    decode = 8'h66;
      4'd5:    decode = 8'h6D;
      4'd6:    decode = 8'h7D;
      4'd7:    decode = 8'h07;
      4'd8:    decode = 8'h7F;
      4'd9:    decode = 8'h6F;
      default: decode = 8'h80;
    endcase
  endfunction

  // Scan starts just after the last served requester, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!grant_found && bus.req[(32'(last) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant       = IDW'((32'(last) + k) % NREQ);
      end
    end
    grant_dig = bus.value[4*grant +: 4];
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cur_id_d = cur_id;
    last_d   = last;
    seg_d    = seg;
    case (state)
      IDLE: begin
        seg_d = '0;
        if (grant_found) begin
          state_d  = SHOW;
          cur_id_d = grant;
          seg_d    = NBITS_SEG'(decode(grant_dig));
          cnt_d    = CNT_LOAD;
        end
      end
      SHOW: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          state_d = IDLE;
          last_d  = cur_id;
          seg_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      cur_id <= '0;
      last   <= LAST_RST;
      seg    <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      cur_id <= cur_id_d;
      last   <= last_d;
      seg    <= seg_d;
    end
  end

  always_comb begin
    bus.ack = '0;
    if (state == SHOW && cnt == '0) bus.ack[cur_id] = 1'b1;
  end

  assign bus.SEG    = seg;
  assign bus.busy   = (state == SHOW);
  assign bus.cur_id = cur_id;
endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: directed scenarios plus random slots,
// each slot predicted as a whole transaction from the round-robin rules.
module tb_seg_display_scheduler;
  localparam int NREQ = 4;
  localparam int HOLD = 4;
  localparam int NSEG = 8;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   m_last;
  int   m_cur;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};

  seg_display_scheduler_if #(.NREQ(NREQ), .NBITS_SEG(NSEG)) bus ();

  seg_display_scheduler #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .NBITS_SEG(NSEG)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // One transaction: present r/v in IDLE, then expect either no grant or a
  // full HOLD-cycle slot of the round-robin winner followed by a blank cycle.
  task automatic slot(input logic [NREQ-1:0] r, input logic [4*NREQ-1:0] v,
                      input bit mid_change, input logic [NREQ-1:0] mid_req);
    int         g;
    logic [3:0] d;
    logic [7:0] exp_seg;
    bus.req   = r;
    bus.value = v;
    chk("idle_seg",  32'(bus.SEG),  32'h0);
    chk("idle_busy", 32'(bus.busy), 32'h0);
    tick();
    if (r == '0) begin
      chk("stay_idle_busy", 32'(bus.busy),   32'h0);
      chk("stay_idle_seg",  32'(bus.SEG),    32'h0);
      chk("stay_idle_ack",  32'(bus.ack),    32'h0);
      chk("stay_idle_cur",  32'(bus.cur_id), 32'(m_cur));
    end else begin
      g       = rr_pick(r, m_last);
      d       = v[4*g +: 4];
      exp_seg = seg_tab[d];
      for (int c = 0; c < HOLD; c++) begin
        chk("show_seg",  32'(bus.SEG),    32'(exp_seg));
        chk("show_busy", 32'(bus.busy),   32'h1);
        chk("show_cur",  32'(bus.cur_id), 32'(g));
        chk("show_ack",  32'(bus.ack),    (c == HOLD - 1) ? (32'h1 << g) : 32'h0);
        if (mid_change) begin
          bus.req   = mid_req;
          bus.value = 16'($urandom);
        end
        tick();
      end
      m_last = g;
      m_cur  = g;
      chk("end_seg",  32'(bus.SEG),    32'h0);
      chk("end_busy", 32'(bus.busy),   32'h0);
      chk("end_ack",  32'(bus.ack),    32'h0);
      chk("end_cur",  32'(bus.cur_id), 32'(g));
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk("rst_seg",  32'(bus.SEG),    32'h0);
      chk("rst_ack",  32'(bus.ack),    32'h0);
      chk("rst_busy", 32'(bus.busy),   32'h0);
      chk("rst_cur",  32'(bus.cur_id), 32'h0);
    end
    reset  = 1'b0;
    m_last = NREQ - 1;
    m_cur  = 0;
  endtask

  initial begin
    bus.req   = '0;
    bus.value = '0;

    do_reset(2);

    slot(4'b0001, 16'h0003, 1'b0, 4'b0000);

    do_reset(1);
    for (int i = 0; i < 5; i++) slot(4'b1111, 16'h3210, 1'b0, 4'b1111);

    slot(4'b0100, 16'h0C00, 1'b0, 4'b0000);

    // Reset in the second SHOW cycle of requester 1: no ack, pointer restarts.
    do_reset(1);
    bus.req   = 4'b0010;
    bus.value = 16'h0050;
    tick();
    chk("pre_rst_cur",  32'(bus.cur_id), 32'h1);
    tick();
    chk("pre_rst_busy", 32'(bus.busy),   32'h1);
    chk("pre_rst_ack",  32'(bus.ack),    32'h0);
    bus.req = 4'b0011;
    do_reset(1);
    slot(4'b0011, 16'h0087, 1'b0, 4'b0011);

    do_reset(1);
    slot(4'b0001, 16'h0009, 1'b1, 4'b0000);
    slot(4'b0010, 16'h0040, 1'b0, 4'b0000);

    slot(4'b0000, 16'h1234, 1'b0, 4'b0000);

    for (int i = 0; i < 40; i++)
      slot(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
